nn_result_collector: RTL and testbench

- Receiving end of the inference datapath: captures the output word stream from the systolic network top and buffers one complete result vector of NOUT words.
- Computes the running argmax (predicted class) while the vector arrives.
- Replays the buffered vector to a host or bench over a ready/valid read port.
- Mirror of the input feeder: the feeder writes one beat per clock into the network; this block reads one beat per clock out of it.

---
 rtl/nn_pkg.sv | 21 ++
 rtl/nn_result_collector_if.sv | 44 ++++
 rtl/nn_argmax_step.sv | 38 +++
 rtl/nn_result_collector.sv | 163 ++++++++++++++++
 tb/tb_nn_result_collector.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the inference result collector.
//   coll_state_t : collector FSM states (COLLECT while the vector arrives,
//                  DRAIN while it is replayed on the read port)
//   NN_DEP       : default word width in bits
//   NN_NOUT      : default number of words per result vector
//   idx_w()      : index width for an n-entry vector, never less than 1
package nn_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } coll_state_t;

    localparam int NN_DEP  = 8;
    localparam int NN_NOUT = 10;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nn_result_collector_if.sv
// Bus bundle for nn_result_collector.
//   in_valid/in_data/in_ready : one beat of COL network output lanes per clock
//   rd_valid/rd_ready/rd_data : replay of the buffered vector, with
//   rd_idx/rd_last              word index and end-of-vector marker
//   class_valid/idx/max       : argmax of the most recently completed vector
//   err                       : sticky flag, a beat was offered while stalled
// The slave modport is the collector side; master is the producer/host side.
interface nn_result_collector_if
    import nn_pkg::*;
#(
    parameter int DEP  = NN_DEP,
    parameter int COL  = 1,
    parameter int NOUT = NN_NOUT
) ();
    localparam int IW = idx_w(NOUT);

    logic           in_valid;
    logic [DEP-1:0] in_data [0:COL-1];
    logic           in_ready;

    logic           rd_valid;
    logic           rd_ready;
    logic [DEP-1:0] rd_data;
    logic [IW-1:0]  rd_idx;
    logic           rd_last;

    logic           class_valid;
    logic [IW-1:0]  class_idx;
    logic [DEP-1:0] class_max;
    logic           err;

    modport slave (
        input  in_valid, in_data, rd_ready,
        output in_ready, rd_valid, rd_data, rd_idx, rd_last,
               class_valid, class_idx, class_max, err
    );

    modport master (
        output in_valid, in_data, rd_ready,
        input  in_ready, rd_valid, rd_data, rd_idx, rd_last,
               class_valid, class_idx, class_max, err
    );

endinterface

// File: rtl/nn_argmax_step.sv
// One combinational argmax update for a beat of COL lanes.
//   cur_max/cur_idx : running maximum and its index before this beat
//   lane            : the beat, lane c holding vector index base+c
//   base            : vector index of lane 0
//   first           : lane 0 is vector word 0 and loads the max unconditionally
//   nxt_max/nxt_idx : running maximum and index after this beat
// Lanes are scanned in ascending order and replace the max only when strictly
// greater, so on a tie the lowest index is kept.
module nn_argmax_step
    import nn_pkg::*;
#(
    parameter int DEP = NN_DEP,
    parameter int COL = 1,
    parameter int IW  = 4
) (
    input  logic [DEP-1:0] cur_max,
    input  logic [IW-1:0]  cur_idx,
    input  logic [DEP-1:0] lane [0:COL-1],
    input  logic [IW-1:0]  base,
    input  logic           first,
    output logic [DEP-1:0] nxt_max,
    output logic [IW-1:0]  nxt_idx
);

    always_comb begin
        // NOTE: outputs take their defaults before the loop so no path leaves
        // them unassigned, which would otherwise infer a latch.
        nxt_max = cur_max;
        nxt_idx = cur_idx;
        for (int c = 0; c < COL; c++) begin
            if ((first && c == 0) || ($signed(lane[c]) > $signed(nxt_max))) begin
                nxt_max = lane[c];
                nxt_idx = base + IW'(c);
            end
        end
    end

endmodule

// File: rtl/nn_result_collector.sv
// Receiving end of the inference datapath.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : nn_result_collector_if.slave
//         - accepts NOUT words, COL per beat, while computing a running
//           signed argmax
//         - on the final beat publishes class_idx/class_max and replays the
//           buffered vector one word per handshake on rd_*
//         - beats offered during replay are dropped and set the sticky err
// NOUT must be a nonzero multiple of COL.
module nn_result_collector
    import nn_pkg::*;
#(
    parameter int DEP  = NN_DEP,
    parameter int COL  = 1,
    parameter int NOUT = NN_NOUT
) (
    input logic            clk,
    input logic            rst,
    nn_result_collector_if.slave bus
);

    localparam int IW = idx_w(NOUT);
    localparam logic [IW:0] NOUT_W = (IW+1)'(NOUT);
    localparam logic [IW:0] LAST_W = (IW+1)'(NOUT - 1);

    coll_state_t    state;
    logic [IW:0]    wr_cnt;
    logic [IW:0]    rd_cnt;

    logic [DEP-1:0] mem [0:NOUT-1];

    logic [DEP-1:0] run_max;
    logic [IW-1:0]  run_idx;

    logic           in_ready_q;
    logic           rd_valid_q;
    logic           rd_last_q;
    logic [DEP-1:0] rd_data_q;
    logic           class_valid_q;
    logic [IW-1:0]  class_idx_q;
    logic [DEP-1:0] class_max_q;
    logic           err_q;

    logic [DEP-1:0] lanes [0:COL-1];
    logic [DEP-1:0] step_max;
    logic [IW-1:0]  step_idx;
    logic           first_beat;
    logic [IW:0]    wr_next;
    logic [IW:0]    rd_next;

    assign lanes      = bus.in_data;
    assign first_beat = (wr_cnt == '0);
    assign wr_next    = wr_cnt + (IW+1)'(COL);
    assign rd_next    = rd_cnt + (IW+1)'(1);

    nn_argmax_step #(
        .DEP (DEP),
        .COL (COL),
        .IW  (IW)
    ) u_step (
        .cur_max (run_max),
        .cur_idx (run_idx),
        .lane    (lanes),
        .base    (wr_cnt[IW-1:0]),
        .first   (first_beat),
        .nxt_max (step_max),
        .nxt_idx (step_idx)
    );

    // NOTE: the vector buffer has no reset; every word read back was written
    // earlier in the same vector, so its power-up contents never escape.
    always_ff @(posedge clk) begin
        if (state == COLLECT && bus.in_valid) begin
            for (int c = 0; c < COL; c++) begin
                mem[wr_cnt[IW-1:0] + IW'(c)] <= lanes[c];
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= COLLECT;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            run_max       <= '0;
            run_idx       <= '0;
            in_ready_q    <= 1'b1;
            rd_valid_q    <= 1'b0;
            rd_last_q     <= 1'b0;
            rd_data_q     <= '0;
            class_valid_q <= 1'b0;
            class_idx_q   <= '0;
            class_max_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            // Only DRAIN deasserts in_ready; the offending beat is simply not
            // written because the buffer only writes in COLLECT.
            if (bus.in_valid && !in_ready_q) begin
                err_q <= 1'b1;
            end

            case (state)
                COLLECT: begin
                    if (bus.in_valid) begin
                        if (first_beat) begin
                            class_valid_q <= 1'b0;
                        end
                        if (wr_next == NOUT_W) begin
                            state         <= DRAIN;
                            wr_cnt        <= '0;
                            class_idx_q   <= step_idx;
                            class_max_q   <= step_max;
                            class_valid_q <= 1'b1;
                            in_ready_q    <= 1'b0;
                            rd_valid_q    <= 1'b1;
                            rd_cnt        <= '0;
                            rd_last_q     <= (NOUT == 1);
                            // When the whole vector fits in one beat, word 0
                            // is being written on this same edge.
                            rd_data_q     <= first_beat ? lanes[0] : mem[0];
                        end else begin
                            wr_cnt  <= wr_next;
                            run_max <= step_max;
                            run_idx <= step_idx;
                        end
                    end
                end

                DRAIN: begin
                    if (bus.rd_ready) begin
                        if (rd_last_q) begin
                            state      <= COLLECT;
                            rd_cnt     <= '0;
                            rd_valid_q <= 1'b0;
                            rd_last_q  <= 1'b0;
                            in_ready_q <= 1'b1;
                        end else begin
                            rd_cnt    <= rd_next;
                            rd_data_q <= mem[rd_next[IW-1:0]];
                            rd_last_q <= (rd_next == LAST_W);
                        end
                    end
                end

                default: state <= COLLECT;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_idx      = rd_cnt[IW-1:0];
    assign bus.rd_last     = rd_last_q;
    assign bus.class_valid = class_valid_q;
    assign bus.class_idx   = class_idx_q;
    assign bus.class_max   = class_max_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_nn_result_collector.sv
// Directed bench for nn_result_collector (DEP=8, COL=1, NOUT=10).
// Inputs change 1 time unit after each rising edge and outputs are sampled
// at the same point, so every sample reflects the state after that edge.
module tb_nn_result_collector;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    nn_result_collector_if #(.DEP(8), .COL(1), .NOUT(10)) bus ();

    nn_result_collector #(.DEP(8), .COL(1), .NOUT(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present the ten words, with 'gap' idle cycles between beats.
    task automatic feed(input logic [7:0] v [10], input int gap);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid   = 1'b1;
            bus.in_data[0] = v[i];
            tick;
            bus.in_valid = 1'b0;
            if (i < 9) repeat (gap) tick;
        end
    endtask

    task automatic expect_class(input string name, input logic [3:0] idx, input logic [7:0] mx);
        n_assert++;
        if (bus.class_valid !== 1'b1 || bus.rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s valid: class_valid=%b rd_valid=%b required 1 1", name, bus.class_valid, bus.rd_valid);
        end
        n_assert++;
        if (bus.class_idx !== idx) begin
            n_fail++;
            $display("FAIL %s class_idx: got %0d required %0d", name, bus.class_idx, idx);
        end
        n_assert++;
        if (bus.class_max !== mx) begin
            n_fail++;
            $display("FAIL %s class_max: got %h required %h", name, bus.class_max, mx);
        end
    endtask

    // Read the whole vector with rd_ready held high and check every word.
    task automatic drain_check(input string name, input logic [7:0] v [10]);
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_assert++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== v[i] || bus.rd_idx !== 4'(i) || bus.rd_last !== (i == 9)) begin
                n_fail++;
                $display("FAIL %s word %0d: valid=%b data=%h idx=%0d last=%b required 1 %h %0d %b",
                         name, i, bus.rd_valid, bus.rd_data, bus.rd_idx, bus.rd_last, v[i], i, (i == 9));
            end
            tick;
        end
        n_assert++;
        if (bus.rd_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s end: rd_valid=%b in_ready=%b required 0 1", name, bus.rd_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset;
        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data[0] = 8'h55;
        bus.rd_ready   = 1'b0;
        tick;
        tick;
        n_assert++;
        if (bus.in_ready !== 1'b1 || bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset flags: in_ready=%b rd_valid=%b rd_last=%b err=%b required 1 0 0 0",
                     bus.in_ready, bus.rd_valid, bus.rd_last, bus.err);
        end
        n_assert++;
        if (bus.class_valid !== 1'b0 || bus.class_idx !== 4'd0 || bus.class_max !== 8'h00) begin
            n_fail++;
            $display("FAIL reset class: valid=%b idx=%0d max=%h required 0 0 00",
                     bus.class_valid, bus.class_idx, bus.class_max);
        end
        n_assert++;
        if (bus.rd_data !== 8'h00 || bus.rd_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL reset read: rd_data=%h rd_idx=%0d required 00 0", bus.rd_data, bus.rd_idx);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        logic [7:0] v [10] = '{8'h05, 8'h10, 8'hF0, 8'h7F, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
        bus.rd_ready = 1'b1;
        feed(v, 0);
        expect_class("basic", 4'd3, 8'h7F);
        drain_check("basic", v);
        n_assert++;
        if (bus.class_valid !== 1'b1 || bus.class_idx !== 4'd3) begin
            n_fail++;
            $display("FAIL basic hold: class_valid=%b class_idx=%0d required 1 3", bus.class_valid, bus.class_idx);
        end
    endtask

    task automatic test_signed_ties;
        logic [7:0] a [10] = '{default: 8'h20};
        logic [7:0] b [10] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'hFF, 8'h80, 8'h80, 8'h80};
        logic [7:0] c [10] = '{8'h00, 8'h10, 8'h7F, 8'h00, 8'h80, 8'h7E, 8'h00, 8'h00, 8'h7F, 8'h01};
        feed(a, 0);
        expect_class("ties_all_equal", 4'd0, 8'h20);
        drain_check("ties_all_equal", a);
        feed(b, 0);
        expect_class("signed_neg", 4'd6, 8'hFF);
        drain_check("signed_neg", b);
        feed(c, 0);
        expect_class("tie_lowest", 4'd2, 8'h7F);
        drain_check("tie_lowest", c);
    endtask

    task automatic test_backpressure;
        logic [7:0] v [10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
        logic [7:0] w [10] = '{8'h03, 8'h09, 8'h02, 8'h01, 8'h00, 8'hFE, 8'h08, 8'h07, 8'h09, 8'h04};
        logic       pat [14] = '{1, 0, 0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1};
        int k = 0;
        feed(v, 0);
        expect_class("bp", 4'd6, 8'h77);
        for (int j = 0; j < 14; j++) begin
            bus.rd_ready = pat[j];
            if (j == 1) begin
                bus.in_valid   = 1'b1;
                bus.in_data[0] = 8'h7F;
            end
            if (j == 3) bus.in_valid = 1'b0;
            n_assert++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== v[k] || bus.rd_idx !== 4'(k)) begin
                n_fail++;
                $display("FAIL bp cycle %0d: valid=%b data=%h idx=%0d required 1 %h %0d",
                         j, bus.rd_valid, bus.rd_data, bus.rd_idx, v[k], k);
            end
            tick;
            if (pat[j]) k++;
        end
        n_assert++;
        if (bus.rd_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.err !== 1'b1) begin
            n_fail++;
            $display("FAIL bp end: rd_valid=%b in_ready=%b err=%b required 0 1 1", bus.rd_valid, bus.in_ready, bus.err);
        end
        bus.rd_ready = 1'b1;
        feed(w, 0);
        expect_class("after_overflow", 4'd1, 8'h09);
        drain_check("after_overflow", w);
        n_assert++;
        if (bus.err !== 1'b1) begin
            n_fail++;
            $display("FAIL err sticky: got %b required 1", bus.err);
        end
    endtask

    task automatic test_gaps;
        logic [7:0] v [10] = '{8'h05, 8'h10, 8'hF0, 8'h7F, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
        feed(v, 1);
        expect_class("gaps", 4'd3, 8'h7F);
        drain_check("gaps", v);
    endtask

    task automatic test_mid_reset;
        logic [7:0] p [10] = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
        logic [7:0] v [10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h50};
        // Reset while draining.
        feed(p, 0);
        bus.rd_ready = 1'b1;
        repeat (3) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_assert++;
        if (bus.rd_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.class_valid !== 1'b0 || bus.class_idx !== 4'd0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL drain reset: rd_valid=%b in_ready=%b class_valid=%b class_idx=%0d err=%b required 0 1 0 0 0",
                     bus.rd_valid, bus.in_ready, bus.class_valid, bus.class_idx, bus.err);
        end
        // Reset after a partial vector of large values.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid   = 1'b1;
            bus.in_data[0] = 8'h7F;
            tick;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        feed(v, 0);
        expect_class("mid_reset", 4'd9, 8'h50);
        drain_check("mid_reset", v);
    endtask

    task automatic test_back_to_back;
        logic [7:0] a [10] = '{8'h05, 8'h10, 8'hF0, 8'h7F, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
        logic [7:0] b [10] = '{8'h81, 8'h82, 8'h90, 8'hF0, 8'hFF, 8'h00, 8'hC0, 8'h10, 8'h7E, 8'h7D};
        feed(a, 0);
        expect_class("b2b_first", 4'd3, 8'h7F);
        drain_check("b2b_first", a);
        bus.in_valid   = 1'b1;
        bus.in_data[0] = b[0];
        tick;
        n_assert++;
        if (bus.class_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b clear: class_valid=%b required 0", bus.class_valid);
        end
        for (int i = 1; i < 10; i++) begin
            bus.in_data[0] = b[i];
            tick;
        end
        bus.in_valid = 1'b0;
        expect_class("b2b_second", 4'd8, 8'h7E);
        drain_check("b2b_second", b);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data[0] = 8'h00;
        bus.rd_ready   = 1'b0;
        test_reset;
        test_basic;
        test_signed_ties;
        test_backpressure;
        test_gaps;
        test_mid_reset;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
